ysyx_25040109_mem_mp: RTL and testbench

Parametrised multi-port memory model for the NPC: NRD independent read channels and one byte-strobed write channel share a single on-chip word array. Read access latency is programmable, and requests use valid/ready handshakes. Every read and write gets a response, with an error flag for out-of-range addresses. It replaces the fixed two-channel imem/dmem model: typically channel 0 serves IFU and channel 1 serves LSU, with extra channels available for a DMA or debug port.

---
 rtl/ysyx_25040109_mem_pkg.sv | 14 +
 rtl/ysyx_25040109_rr_arb.sv | 39 +++
 rtl/ysyx_25040109_mem_mp.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_25040109_mem_mp.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040109_mem_pkg.sv
// Shared types and constants for the NPC multi-port memory model.
package ysyx_25040109_mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rd_state_e;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;
    localparam int NRD_MIN = 1;
    localparam int NRD_MAX = 8;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;
endpackage

// File: rtl/ysyx_25040109_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted requester.
module ysyx_25040109_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gnt_idx;

    // Walk from farthest to nearest so the requester closest after ptr_q wins.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = ptr_q;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else if (adv) begin
            ptr_q <= gnt_idx;
        end
    end
endmodule

// File: rtl/ysyx_25040109_mem_mp.sv
// Multi-port memory model: NRD latency-programmable read channels and one
// byte-strobed write channel over a single word array.
module ysyx_25040109_mem_mp
    import ysyx_25040109_mem_pkg::*;
#(
    parameter int          NRD       = 2,
    parameter int          LATENCY   = 2,
    parameter int          AW        = 16,
    parameter logic [31:0] BASE      = MEM_BASE_DEFAULT,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD-1:0]    rd_valid,
    output logic [NRD-1:0]    rd_ready,
    input  logic [32*NRD-1:0] rd_addr,
    output logic [NRD-1:0]    rsp_valid,
    input  logic [NRD-1:0]    rsp_ready,
    output logic [32*NRD-1:0] rsp_data,
    output logic [NRD-1:0]    rsp_err,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    output logic              b_valid,
    input  logic              b_ready,
    output logic              b_err
);
    localparam int CW    = 4;
    localparam int DEPTH = 1 << AW;

    if (NRD < NRD_MIN || NRD > NRD_MAX) begin : g_bad_nrd
        $error("ysyx_25040109_mem_mp: NRD out of range");
    end
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
        $error("ysyx_25040109_mem_mp: LATENCY out of range");
    end

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return {2'b00, off} < (34'd4 << AW);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off[AW+1:2];
    endfunction

    logic [31:0]   mem [DEPTH];
    rd_state_e     state_q [NRD];
    rd_state_e     state_d [NRD];
    logic [CW-1:0] cnt_q   [NRD];
    logic [AW-1:0] idx_q   [NRD];
    logic [NRD-1:0] err_q, req, gnt, rd_hs, enter_resp;
    logic [AW-1:0] sel_idx;
    logic          sel_err;
    logic [31:0]   rd_word;
    logic          wr_hs;

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            req[i]       = rd_valid[i] && (state_q[i] == ST_IDLE);
            rsp_valid[i] = (state_q[i] == ST_RESP);
        end
    end

    ysyx_25040109_rr_arb #(.N(NRD)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .adv (|rd_hs),
        .gnt (gnt)
    );

    assign rd_ready = {NRD{!rst}} & gnt;
    assign rd_hs    = rd_valid & rd_ready;

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            state_d[i]    = state_q[i];
            enter_resp[i] = 1'b0;
            case (state_q[i])
                ST_IDLE: if (rd_hs[i]) begin
                    if (LATENCY == 1) begin
                        state_d[i]    = ST_RESP;
                        enter_resp[i] = 1'b1;
                    end else begin
                        state_d[i] = ST_WAIT;
                    end
                end
                // Counter hits zero on this edge.
                ST_WAIT: if (cnt_q[i] <= CW'(1)) begin
                    state_d[i]    = ST_RESP;
                    enter_resp[i] = 1'b1;
                end
                ST_RESP: if (rsp_ready[i]) state_d[i] = ST_IDLE;
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Grants are one per cycle with fixed latency, so at most one channel enters RESP per edge.
    always_comb begin
        sel_idx = '0;
        sel_err = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (enter_resp[i]) begin
                if (LATENCY == 1) begin
                    sel_idx = word_idx(rd_addr[32*i +: 32]);
                    sel_err = !in_range(rd_addr[32*i +: 32]);
                end else begin
                    sel_idx = idx_q[i];
                    sel_err = err_q[i];
                end
            end
        end
    end

    assign rd_word = mem[sel_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NRD; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NRD; i++) begin
                state_q[i] <= state_d[i];
                if (rd_hs[i]) cnt_q[i] <= CW'(LATENCY - 1);
                else if (state_q[i] == ST_WAIT) cnt_q[i] <= cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NRD; i++) begin
            if (rd_hs[i]) begin
                idx_q[i] <= word_idx(rd_addr[32*i +: 32]);
                err_q[i] <= !in_range(rd_addr[32*i +: 32]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_err  <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (enter_resp[i]) begin
                    rsp_data[32*i +: 32] <= sel_err ? 32'h0 : rd_word;
                    rsp_err[i]           <= sel_err;
                end
            end
        end
    end

    assign wr_ready = !rst && !b_valid;
    assign wr_hs    = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (wr_hs && in_range(wr_addr)) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_strb[k]) mem[word_idx(wr_addr)][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_err   <= 1'b0;
        end else if (wr_hs) begin
            b_valid <= 1'b1;
            b_err   <= !in_range(wr_addr);
        end else if (b_valid && b_ready) begin
            b_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ysyx_25040109_mem_mp.sv
// Directed self-checking bench for ysyx_25040109_mem_mp (NRD=2, LATENCY=2, AW=16).
module tb_ysyx_25040109_mem_mp;
    localparam logic [31:0] B   = 32'h8000_0000;
    localparam int          LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_valid, rd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rd_addr, rsp_data;
    logic        wr_valid, wr_ready, b_valid, b_ready, b_err;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_25040109_mem_mp #(.NRD(2), .LATENCY(LAT), .AW(16), .BASE(B), .INIT_FILE("")) dut (
        .clk (clk), .rst (rst),
        .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_addr (rd_addr),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data), .rsp_err (rsp_err),
        .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_addr (wr_addr), .wr_data (wr_data),
        .wr_strb (wr_strb), .b_valid (b_valid), .b_ready (b_ready), .b_err (b_err)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic exp_err);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = addr; wr_data = data; wr_strb = strb;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (wr_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        expect_eq("wr_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        expect_eq("b_valid_rise", {31'd0, b_valid}, 32'd1);
        expect_eq("b_err", {31'd0, b_err}, {31'd0, exp_err});
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        expect_eq("b_valid_fall", {31'd0, b_valid}, 32'd0);
    endtask

    task automatic do_read(input int ch, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        rd_valid[ch] = 1'b1;
        rd_addr[32*ch +: 32] = addr;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (rd_ready[ch]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        expect_eq("rd_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rd_valid[ch] = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            expect_eq("rsp_early", {31'd0, rsp_valid[ch]}, 32'd0);
            @(negedge clk);
        end
        expect_eq("rsp_valid", {31'd0, rsp_valid[ch]}, 32'd1);
        expect_eq("rsp_data", rsp_data[32*ch +: 32], exp_data);
        expect_eq("rsp_err", {31'd0, rsp_err[ch]}, {31'd0, exp_err});
        if (rsp_ready[ch]) begin
            @(negedge clk);
            expect_eq("rsp_drop", {31'd0, rsp_valid[ch]}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rd_valid = '0; rd_addr = '0; rsp_ready = 2'b11;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; b_ready = 1'b0;
        repeat (2) @(negedge clk);
        rd_valid = 2'b01; rd_addr[31:0] = B;
        wr_valid = 1'b1; wr_addr = B; wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
        #1;
        expect_eq("rst_rd_ready", {30'd0, rd_ready}, 32'd0);
        expect_eq("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        rd_valid = '0; wr_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        expect_eq("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        expect_eq("rst_rsp_data0", rsp_data[31:0], 32'd0);
        expect_eq("rst_rsp_data1", rsp_data[63:32], 32'd0);
        expect_eq("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
        expect_eq("rst_b_valid", {31'd0, b_valid}, 32'd0);
        expect_eq("rst_b_err", {31'd0, b_err}, 32'd0);
        expect_eq("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Preload, basic read, strobed write and strb=0 write
        do_write(B, 32'h0000_0013, 4'hF, 1'b0);
        do_write(B + 32'd4, 32'h1122_3344, 4'hF, 1'b0);
        do_read(0, B, 32'h0000_0013, 1'b0);
        do_write(B + 32'd4, 32'hAABB_CCDD, 4'b0101, 1'b0);
        do_read(1, B + 32'd4, 32'h11BB_33DD, 1'b0);
        do_write(B + 32'd4, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        do_read(0, B + 32'd4, 32'h11BB_33DD, 1'b0);

        // Address range boundaries
        do_read(0, 32'h7FFF_FFFC, 32'h0, 1'b1);
        do_write(32'h8004_0000, 32'hDEAD_BEEF, 4'hF, 1'b1);
        do_read(0, B, 32'h0000_0013, 1'b0);
        do_write(32'h8003_FFFC, 32'hCAFE_F00D, 4'hF, 1'b0);
        do_read(1, 32'h8003_FFFC, 32'hCAFE_F00D, 1'b0);

        // Round robin with both channels requesting; last grant was ch1
        @(negedge clk);
        rd_valid = 2'b11; rd_addr = {B + 32'd4, B};
        for (int t = 0; t < 9; t++) begin
            logic [1:0] exp_rdy, exp_rsp;
            #1;
            case (t % 3)
                0: exp_rdy = 2'b01;
                1: exp_rdy = 2'b10;
                default: exp_rdy = 2'b00;
            endcase
            case (t)
                2, 5, 8: exp_rsp = 2'b01;
                3, 6:    exp_rsp = 2'b10;
                default: exp_rsp = 2'b00;
            endcase
            expect_eq("rr_grant", {30'd0, rd_ready}, {30'd0, exp_rdy});
            expect_eq("rr_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rsp});
            if (t == 2) expect_eq("rr_data0", rsp_data[31:0], 32'h0000_0013);
            if (t == 3) expect_eq("rr_data1", rsp_data[63:32], 32'h11BB_33DD);
            @(negedge clk);
        end
        rd_valid = '0;
        repeat (4) @(negedge clk);
        expect_eq("rr_drained", {30'd0, rsp_valid}, 32'd0);

        // ch1 response stalled while ch0 keeps completing reads
        rsp_ready[1] = 1'b0;
        rd_valid[1] = 1'b1; rd_addr[63:32] = B + 32'd4;
        #1;
        expect_eq("stall_accept", {31'd0, rd_ready[1]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rd_valid[1] = 1'b0;
        @(negedge clk);
        expect_eq("stall_valid", {31'd0, rsp_valid[1]}, 32'd1);
        for (int r = 0; r < 3; r++) begin
            do_read(0, B, 32'h0000_0013, 1'b0);
            expect_eq("stall_hold_v", {31'd0, rsp_valid[1]}, 32'd1);
            expect_eq("stall_hold_d", rsp_data[63:32], 32'h11BB_33DD);
            expect_eq("stall_hold_e", {31'd0, rsp_err[1]}, 32'd0);
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        expect_eq("stall_release", {31'd0, rsp_valid[1]}, 32'd0);

        // Reset while ch0 is in WAIT and b_valid is high
        @(negedge clk);
        rd_valid[0] = 1'b1; rd_addr[31:0] = B;
        wr_valid = 1'b1; wr_addr = B + 32'd8; wr_data = 32'h0000_0055; wr_strb = 4'hF;
        #1;
        expect_eq("mid_rd_accept", {31'd0, rd_ready[0]}, 32'd1);
        expect_eq("mid_wr_accept", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        rd_valid = '0; wr_valid = 1'b0;
        expect_eq("mid_b_valid", {31'd0, b_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            expect_eq("mid_rsp_dropped", {30'd0, rsp_valid}, 32'd0);
            expect_eq("mid_b_dropped", {31'd0, b_valid}, 32'd0);
            @(negedge clk);
        end

        // A write presented while rst is high must not land
        wr_valid = 1'b1; wr_addr = B + 32'd8; wr_data = 32'hBAD0_0BAD; wr_strb = 4'hF;
        rst = 1'b1;
        #1;
        expect_eq("rst_wr_blocked", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0;
        do_read(0, B + 32'd8, 32'h0000_0055, 1'b0);
        do_read(1, B, 32'h0000_0013, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
